// File: rtl/aurora_pipe_pkg.sv
// Shared fetch-pipe constants: PC geometry, boot timing and fetch FSM encoding.
package aurora_pipe_pkg;

   localparam int             PC_W        = 8;
   localparam logic [PC_W-1:0] RESET_PC   = 8'h00;
   localparam logic [PC_W-1:0] PC_INC     = 8'd1;
   localparam int             BOOT_CYC    = 2;
   localparam int             BOOT_CNT_W  = $clog2(BOOT_CYC) + 1;
   localparam int             FETCH_CNT_W = 16;

   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] REDIR = 2'd2;
   localparam logic [1:0] HALT  = 2'd3;

endpackage

// File: rtl/if_pc_gen_if.sv
// IF/ID producer-side bundle: control inputs from the pipeline, PC/slot outputs to IF/ID and IMEM.
interface if_pc_gen_if;
   import aurora_pipe_pkg::*;

   logic                   stall_in;
   logic                   branch_taken_in;
   logic [PC_W-1:0]        branch_target_in;
   logic                   halt_in;
   logic [PC_W-1:0]        PC_out;
   logic                   wb_ff_out;
   logic [PC_W-1:0]        imem_addr_out;
   logic                   halted_out;
   logic [FETCH_CNT_W-1:0] fetch_cnt_out;

   modport master (
      input  stall_in, branch_taken_in, branch_target_in, halt_in,
      output PC_out, wb_ff_out, imem_addr_out, halted_out, fetch_cnt_out
   );

   modport slave (
      output stall_in, branch_taken_in, branch_target_in, halt_in,
      input  PC_out, wb_ff_out, imem_addr_out, halted_out, fetch_cnt_out
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/if_pc_gen.sv
// Fetch-side PC generator: sequences the IF/ID PC and valid-slot flag through boot, run, redirect, stall and halt.
module if_pc_gen
   import aurora_pipe_pkg::*;
(
   input  logic          CLK,
   input  logic          RST,
   if_pc_gen_if.master   bus
);

   logic [1:0]            state_q, state_d;
   logic [PC_W-1:0]       pc_q, pc_d;
   logic                  wb_q, wb_d;
   logic [BOOT_CNT_W-1:0] boot_q, boot_d;
   logic                  fetch_inc;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wb_d    = wb_q;
      boot_d  = boot_q;
      case (state_q)
         BOOT: begin
            if (bus.halt_in) begin
               state_d = HALT;
               wb_d    = 1'b0;
            end else if (boot_q == BOOT_CNT_W'(BOOT_CYC - 1)) begin
               state_d = RUN;
               wb_d    = 1'b1;
            end else begin
               boot_d = boot_q + 1'b1;
            end
         end
         RUN: begin
            if (bus.halt_in) begin
               state_d = HALT;
               wb_d    = 1'b0;
            end else if (bus.branch_taken_in) begin
               state_d = REDIR;
               pc_d    = bus.branch_target_in;
               wb_d    = 1'b0;
            end else if (!bus.stall_in) begin
               pc_d = pc_q + PC_INC;
               wb_d = 1'b1;
            end
         end
         REDIR: begin
            // The target already sits in pc_q; leaving REDIR issues it rather than skipping it.
            if (bus.halt_in) begin
               state_d = HALT;
               wb_d    = 1'b0;
            end else if (bus.branch_taken_in) begin
               pc_d = bus.branch_target_in;
               wb_d = 1'b0;
            end else if (!bus.stall_in) begin
               state_d = RUN;
               wb_d    = 1'b1;
            end
         end
         default: begin
            wb_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         wb_q    <= 1'b0;
         boot_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wb_q    <= wb_d;
         boot_q  <= boot_d;
      end
   end

   assign fetch_inc = wb_q & ~bus.stall_in;

   sat_counter #(
      .WIDTH (FETCH_CNT_W)
   ) u_fetch_cnt (
      .clk   (CLK),
      .rst_n (RST),
      .inc_i (fetch_inc),
      .cnt_o (bus.fetch_cnt_out)
   );

   assign bus.PC_out        = pc_q;
   assign bus.wb_ff_out     = wb_q;
   assign bus.imem_addr_out = pc_q;
   assign bus.halted_out    = (state_q == HALT);

endmodule

// File: tb/tb_if_pc_gen.sv
// Randomized bench for if_pc_gen: a per-cycle reference model feeds a scoreboard queue drained by a monitor.
module tb_if_pc_gen;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   if_pc_gen_if bus ();

   if_pc_gen dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   logic       sc_rst_n = 1'b0;
   logic       sc_inc   = 1'b0;
   logic [3:0] sc_cnt;

   sat_counter #(.WIDTH(4)) u_sc (
      .clk   (CLK),
      .rst_n (sc_rst_n),
      .inc_i (sc_inc),
      .cnt_o (sc_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] pc;
      bit         wb;
      bit         halted;
      int         cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: plain bookkeeping of bubbles left, redirect pending, halted.
   logic [7:0] m_pc;
   bit         m_wb;
   bit         m_halt;
   bit         m_redir;
   int         m_boot_left;
   int         m_cnt;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_wb = 0; m_halt = 0; m_redir = 0; m_boot_left = 2; m_cnt = 0;
   endtask

   task automatic model_step(input bit st, input bit br, input logic [7:0] tgt, input bit hl);
      if (m_wb && !st && m_cnt < 65535) m_cnt++;
      if (m_halt) begin
      end else if (hl) begin
         m_halt = 1; m_wb = 0;
      end else if (m_boot_left > 0) begin
         m_boot_left--;
         if (m_boot_left == 0) m_wb = 1;
      end else if (br) begin
         m_pc = tgt; m_wb = 0; m_redir = 1;
      end else if (st) begin
      end else if (m_redir) begin
         m_redir = 0; m_wb = 1;
      end else begin
         m_pc = m_pc + 8'd1; m_wb = 1;
      end
   endtask

   task automatic cycle(input bit st, input bit br, input logic [7:0] tgt, input bit hl);
      exp_t e;
      @(negedge CLK);
      RST = 1'b1;
      bus.stall_in = st; bus.branch_taken_in = br; bus.branch_target_in = tgt; bus.halt_in = hl;
      model_step(st, br, tgt, hl);
      e.pc = m_pc; e.wb = m_wb; e.halted = m_halt; e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_now();
      chk("rst_pc",     int'(bus.PC_out),        0);
      chk("rst_imem",   int'(bus.imem_addr_out), 0);
      chk("rst_wb",     int'(bus.wb_ff_out),     0);
      chk("rst_halted", int'(bus.halted_out),    0);
      chk("rst_cnt",    int'(bus.fetch_cnt_out), 0);
   endtask

   // Asserts reset between edges and checks outputs before the next edge.
   task automatic do_reset();
      @(posedge CLK);
      #3;
      RST = 1'b0;
      model_reset();
      #1;
      check_reset_now();
      @(negedge CLK);
   endtask

   task automatic run_to(input logic [7:0] pc);
      int n = 0;
      while (!(m_pc == pc && m_wb && !m_halt)) begin
         cycle(0, 0, 8'h00, 0);
         n++;
         if (n > 600) begin
            chk("run_to_bound", n, 0);
            break;
         end
      end
   endtask

   task automatic rand_cycles(input int n, input int halt_mod);
      for (int i = 0; i < n; i++) begin
         cycle(($urandom % 4) == 0, ($urandom % 6) == 0, 8'($urandom),
               (halt_mod != 0) && (($urandom % halt_mod) == 0));
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc",     int'(bus.PC_out),        int'(e.pc));
            chk("imem",   int'(bus.imem_addr_out), int'(e.pc));
            chk("wb",     int'(bus.wb_ff_out),     int'(e.wb));
            chk("halted", int'(bus.halted_out),    int'(e.halted));
            chk("cnt",    int'(bus.fetch_cnt_out), e.cnt);
         end
      end
   end

   initial begin : stim
      int sc_exp;
      bus.stall_in = 0; bus.branch_taken_in = 0; bus.branch_target_in = '0; bus.halt_in = 0;
      model_reset();
      repeat (2) @(negedge CLK);
      do_reset();
      repeat (6) cycle(0, 0, 8'h00, 0);
      run_to(8'h05);
      repeat (3) cycle(1, 0, 8'h00, 0);
      repeat (2) cycle(0, 0, 8'h00, 0);
      run_to(8'h10);
      cycle(0, 1, 8'h40, 0);
      repeat (4) cycle(0, 0, 8'h00, 0);
      cycle(1, 1, 8'hF8, 0);
      cycle(1, 0, 8'h00, 0);
      cycle(0, 1, 8'hF9, 0);
      run_to(8'hFF);
      repeat (3) cycle(0, 0, 8'h00, 0);
      rand_cycles(400, 0);
      cycle(0, 1, 8'h1C, 0);
      run_to(8'h20);
      cycle(0, 0, 8'h00, 1);
      rand_cycles(12, 0);
      do_reset();
      repeat (4) cycle(0, 0, 8'h00, 0);
      cycle(0, 1, 8'h77, 0);
      do_reset();
      cycle(0, 0, 8'h00, 1);
      rand_cycles(5, 0);
      do_reset();
      rand_cycles(300, 40);
      @(posedge CLK);
      #2;
      chk("queue_drained", exp_q.size(), 0);

      // Saturation of the fetch counter, exercised on a narrow instance.
      sc_exp = 0;
      @(negedge CLK);
      sc_rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         sc_inc = (i != 3);
         if (sc_inc && sc_exp < 15) sc_exp++;
         @(posedge CLK);
         #1;
         chk("sat_cnt", int'(sc_cnt), sc_exp);
      end
      #2;
      sc_rst_n = 1'b0;
      #1;
      chk("sat_clr", int'(sc_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
